// File: rtl/sdram_tb_pkg.sv
// Shared address-field layout and widths for the SDRAM reference model.
package sdram_tb_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;

  localparam int REGION_MSB = 31;
  localparam int REGION_LSB = 30;
  localparam int COL_MSB    = 24;
  localparam int COL_LSB    = 16;
  localparam int BANK_MSB   = 15;
  localparam int BANK_LSB   = 14;
  localparam int ROW_MSB    = 13;
  localparam int ROW_LSB    = 0;

  localparam int BANK_W     = BANK_MSB - BANK_LSB + 1;
  localparam int ROW_W      = ROW_MSB - ROW_LSB + 1;
  localparam int COL_W      = COL_MSB - COL_LSB + 1;

  localparam logic [1:0] REGION_CODE = 2'b10;

  // Decoded view of a bus address.
  typedef struct packed {
    logic              in_region;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
  } addr_fields_t;

  // Split an address into its region flag and bank/row/column fields.
  function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
    addr_fields_t f;
    f.in_region = (addr[REGION_MSB:REGION_LSB] == REGION_CODE);
    f.bank      = addr[BANK_MSB:BANK_LSB];
    f.row       = addr[ROW_MSB:ROW_LSB];
    f.col       = addr[COL_MSB:COL_LSB];
    return f;
  endfunction

endpackage

// File: rtl/sdram_addr_decode.sv
// Combinational address decoder: region check, field split and shadow-memory index.
// Only the low ROW_IDX row bits and COL_IDX column bits reach the index, so
// higher row/column bits alias onto the same word by design.
module sdram_addr_decode
  import sdram_tb_pkg::*;
#(
  parameter int ROW_IDX = 4,
  parameter int COL_IDX = 6,
  parameter int IDX_W   = BANK_W + ROW_IDX + COL_IDX
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_region,
  output logic [BANK_W-1:0] bank,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [IDX_W-1:0]  idx
);

  addr_fields_t fields_s;
  logic         unused_bits_s;

  // Bits [29:25] carry no meaning for decode or indexing.
  assign unused_bits_s = ^addr[29:25];

  // Field extraction and index concatenation.
  always_comb begin
    fields_s  = split_addr(addr);
    in_region = fields_s.in_region;
    bank      = fields_s.bank;
    row       = fields_s.row;
    col       = fields_s.col;
    idx       = {fields_s.bank, fields_s.row[ROW_IDX-1:0], fields_s.col[COL_IDX-1:0]};
  end

endmodule

// File: rtl/sdram_ref_model.sv
// Zero-wait-state golden model of the SDRAM controller data path.
// Shadows bus writes into a small memory with per-word valid bits and
// produces the expected read data one cycle after a read is sampled.
module sdram_ref_model
  import sdram_tb_pkg::*;
#(
  parameter int ROW_IDX = 4,
  parameter int COL_IDX = 6,
  parameter int DATA_W  = sdram_tb_pkg::DATA_W
) (
  input  logic              tb_HCLK,
  input  logic              tb_HRESET,
  input  logic              tb_HSEL,
  input  logic              tb_HWRITE,
  input  logic [31:0]       tb_HADDR,
  input  logic [DATA_W-1:0] tb_HWDATA,
  output logic [DATA_W-1:0] golden_HRDATA
);

  localparam int IDX_W = BANK_W + ROW_IDX + COL_IDX;
  localparam int DEPTH = 1 << IDX_W;

  logic              in_region_s;
  logic [BANK_W-1:0] bank_s;
  logic [ROW_W-1:0]  row_s;
  logic [COL_W-1:0]  col_s;
  logic [IDX_W-1:0]  idx_s;
  logic              unused_fields_s;

  logic              wr_en_s;
  logic              rd_en_s;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  valid_r;
  logic [DATA_W-1:0] rdata_r;

  sdram_addr_decode #(
    .ROW_IDX (ROW_IDX),
    .COL_IDX (COL_IDX),
    .IDX_W   (IDX_W)
  ) u_decode (
    .addr      (tb_HADDR),
    .in_region (in_region_s),
    .bank      (bank_s),
    .row       (row_s),
    .col       (col_s),
    .idx       (idx_s)
  );

  // The split fields are only observed through the index here.
  assign unused_fields_s = ^{bank_s, row_s, col_s};

  // Transfer qualification: out-of-region writes are dropped.
  always_comb begin
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    if (tb_HSEL) begin
      wr_en_s = tb_HWRITE & in_region_s;
      rd_en_s = ~tb_HWRITE;
    end else begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end
  end

  // Shadow data array; never reset, unwritten words are masked by valid_r.
  always_ff @(posedge tb_HCLK) begin
    if (!tb_HRESET && wr_en_s) begin
      mem_r[idx_s] <= tb_HWDATA;
    end
  end

  // Per-word valid bits, cleared by reset so stale data never reads back.
  always_ff @(posedge tb_HCLK or posedge tb_HRESET) begin
    if (tb_HRESET) begin
      valid_r <= {DEPTH{1'b0}};
    end else if (wr_en_s) begin
      valid_r[idx_s] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Expected read data: loads on every sampled read, holds otherwise.
  always_ff @(posedge tb_HCLK or posedge tb_HRESET) begin
    if (tb_HRESET) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (rd_en_s) begin
      if (in_region_s && valid_r[idx_s]) begin
        rdata_r <= mem_r[idx_s];
      end else begin
        rdata_r <= {DATA_W{1'b0}};
      end
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign golden_HRDATA = rdata_r;

endmodule

// File: tb/tb_sdram_ref_model.sv
// Directed bench for sdram_ref_model: a word-addressed behavioural model is
// compared against the DUT on every falling edge, plus literal spot checks.
module tb_sdram_ref_model;

  logic        tb_HCLK;
  logic        tb_HRESET;
  logic        tb_HSEL;
  logic        tb_HWRITE;
  logic [31:0] tb_HADDR;
  logic [31:0] tb_HWDATA;
  logic [31:0] golden_HRDATA;

  int tests;
  int fails;

  // Behavioural model state.
  logic [31:0] m_data  [4096];
  bit          m_valid [4096];
  logic [31:0] m_rdata;

  sdram_ref_model #(
    .ROW_IDX (4),
    .COL_IDX (6),
    .DATA_W  (32)
  ) dut (
    .tb_HCLK       (tb_HCLK),
    .tb_HRESET     (tb_HRESET),
    .tb_HSEL       (tb_HSEL),
    .tb_HWRITE     (tb_HWRITE),
    .tb_HADDR      (tb_HADDR),
    .tb_HWDATA     (tb_HWDATA),
    .golden_HRDATA (golden_HRDATA)
  );

  initial tb_HCLK = 1'b0;
  always #5 tb_HCLK = ~tb_HCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Word index from the address arithmetic: 1024 words per bank, 64 per row,
  // row taken modulo 16 and column modulo 64.
  function automatic int word_of(input logic [31:0] a);
    int b;
    int r;
    int c;
    b = int'((a >> 14) & 32'd3);
    r = int'(a & 32'h3FFF) % 16;
    c = int'((a >> 16) & 32'h1FF) % 64;
    return b * 1024 + r * 64 + c;
  endfunction

  // Model: apply the transfer presented at each rising edge, reset at once.
  initial begin
    for (int i = 0; i < 4096; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 32'h0;
    end
    m_rdata = 32'h0;
    forever begin
      @(posedge tb_HCLK or posedge tb_HRESET);
      if (tb_HRESET) begin
        for (int i = 0; i < 4096; i++) m_valid[i] = 1'b0;
        m_rdata = 32'h0;
      end else if (tb_HSEL) begin
        if (tb_HADDR[31:30] == 2'b10) begin
          if (tb_HWRITE) begin
            m_data[word_of(tb_HADDR)]  = tb_HWDATA;
            m_valid[word_of(tb_HADDR)] = 1'b1;
          end else begin
            m_rdata = m_valid[word_of(tb_HADDR)] ? m_data[word_of(tb_HADDR)] : 32'h0;
          end
        end else if (!tb_HWRITE) begin
          m_rdata = 32'h0;
        end
      end
    end
  end

  // Cycle compare against the model on every falling edge.
  initial begin
    forever begin
      @(negedge tb_HCLK);
      check("model", golden_HRDATA, m_rdata);
    end
  end

  task automatic xfer(input logic sel, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge tb_HCLK);
    #1;
    tb_HSEL   = sel;
    tb_HWRITE = wr;
    tb_HADDR  = a;
    tb_HWDATA = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    xfer(1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) xfer(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Present a read, let it be sampled, then check the literal expectation.
  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    xfer(1'b1, 1'b0, a, 32'h0);
    @(posedge tb_HCLK);
    @(negedge tb_HCLK);
    check(name, golden_HRDATA, exp);
  endtask

  // Directed stimulus.
  initial begin
    tests     = 0;
    fails     = 0;
    tb_HRESET = 1'b1;
    tb_HSEL   = 1'b0;
    tb_HWRITE = 1'b0;
    tb_HADDR  = 32'h0;
    tb_HWDATA = 32'h0;
    #100;
    tb_HRESET = 1'b0;
    @(negedge tb_HCLK);
    check("reset_value", golden_HRDATA, 32'h0);

    // Basic write/read.
    wr(32'h8000_0000, 32'h4985_6712);
    idle(5);
    rd_check("basic_read", 32'h8000_0000, 32'h4985_6712);

    // Bank/row/column isolation.
    wr(32'h8000_4000, 32'hA5A5_A5A5);
    wr(32'h8001_0000, 32'h5A5A_5A5A);
    wr(32'h8000_0001, 32'h1234_5678);
    rd_check("bank1",  32'h8000_4000, 32'hA5A5_A5A5);
    rd_check("col1",   32'h8001_0000, 32'h5A5A_5A5A);
    rd_check("row1",   32'h8000_0001, 32'h1234_5678);
    rd_check("base",   32'h8000_0000, 32'h4985_6712);

    // Region filter and don't-care bits.
    wr(32'h0000_0000, 32'hDEAD_BEEF);
    rd_check("oor_read",  32'h0000_0000, 32'h0);
    rd_check("base_kept", 32'h8000_0000, 32'h4985_6712);
    rd_check("dontcare",  32'h8200_0000, 32'h4985_6712);
    idle(2);
    @(negedge tb_HCLK);
    check("idle_hold", golden_HRDATA, 32'h4985_6712);

    // Write then read of the same word on the very next cycle.
    wr(32'h8000_0003, 32'h0000_0077);
    rd_check("wr_then_rd", 32'h8000_0003, 32'h0000_0077);

    // Unwritten word, then asynchronous reset between edges.
    rd_check("unwritten", 32'h8002_0000, 32'h0);
    wr(32'h8002_0000, 32'hCAFE_F00D);
    rd_check("before_rst", 32'h8002_0000, 32'hCAFE_F00D);
    idle(1);
    #1;
    tb_HRESET = 1'b1;
    #1;
    check("async_reset", golden_HRDATA, 32'h0);
    #1;
    tb_HRESET = 1'b0;
    rd_check("after_rst",      32'h8002_0000, 32'h0);
    rd_check("after_rst_base", 32'h8000_0000, 32'h0);

    // Aliasing: row 16 lands on row 0.
    wr(32'h8000_0010, 32'h1111_1111);
    rd_check("alias", 32'h8000_0000, 32'h1111_1111);

    // Held read over four sampled edges, then hold after deselect.
    rd_check("pre_hold", 32'h8000_4000, 32'h0);
    xfer(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge tb_HCLK);
      @(negedge tb_HCLK);
      check("held_read", golden_HRDATA, 32'h1111_1111);
    end
    #1;
    tb_HSEL = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge tb_HCLK);
      @(negedge tb_HCLK);
      check("held_idle", golden_HRDATA, 32'h1111_1111);
    end

    idle(2);
    @(negedge tb_HCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_ref_model.md
Name: sdram_ref_model

Overview:
- Cycle-based reference (golden) model of the AHB-style SDRAM controller's data path.
- Sits beside sdram_top in the verification environment and watches the same bus signals (HSEL, HWRITE, HADDR, HWDATA).
- Keeps a shadow memory and drives the expected read data, golden_HRDATA, which the checker and scoreboard compare against the controller's HRDATA.
- Zero-wait-state model: it does not observe HREADY.

Parameters:
- ROW_IDX, 4: number of low row-address bits used to index the shadow memory.
- COL_IDX, 6: number of low column-address bits used to index the shadow memory.
- DATA_W, 32: data width.

Ports:
- tb_HCLK  input  1  clock; all state updates on the rising edge.
- tb_HRESET  input  1  reset, asynchronous, active-high.
- tb_HSEL  input  1  slave select; a transfer is active when high.
- tb_HWRITE  input  1  1 = write, 0 = read.
- tb_HADDR  input  32  address: [31:30] region, [29:25] unused, [24:16] column, [15:14] bank, [13:0] row.
- tb_HWDATA  input  32  write data, sampled in the same cycle as the address.
- golden_HRDATA  output  32  expected read data, registered.

Behaviour:
- Reset:
  - Asynchronous assertion sets golden_HRDATA = 32'h0 and clears every per-word valid bit.
  - Memory data need not be cleared.
  - While reset is asserted, all bus inputs are ignored.
- Region decode:
  - A transfer is in-region when tb_HADDR[31:30] == 2'b10.
  - Bits [29:25] are don't-care and do not affect decode or indexing.
- Index:
  - idx = {bank[1:0], row[ROW_IDX-1:0], col[COL_IDX-1:0]}, 12 bits by default, giving 4096 words.
  - Higher row and column bits alias onto the same word. This is intentional and documented.
- Write, when tb_HSEL=1, tb_HWRITE=1 and in-region, at the rising edge:
  - mem[idx] <= tb_HWDATA; valid[idx] <= 1.
  - golden_HRDATA is unchanged.
- Read, when tb_HSEL=1, tb_HWRITE=0 and in-region, at the rising edge:
  - golden_HRDATA <= valid[idx] ? mem[idx] : 32'h0.
  - Latency is 1 cycle: the value is visible after the edge that samples the address.
- Out-of-region transfers:
  - Writes are discarded.
  - Reads load golden_HRDATA <= 32'h0.
- Idle (tb_HSEL=0): golden_HRDATA holds its last value; memory is unchanged.
- Held transfers: if the stimulus holds a transfer for several cycles (waiting on the DUT's HREADY), the model repeats it every cycle.
  - Repeated writes are idempotent.
  - Repeated reads re-load the same value.
- Write followed by a read of the same idx on the next cycle returns the newly written data.
- Only one operation per cycle, so there is no same-cycle read/write hazard.
- Reset mid-sequence takes effect immediately. The first read of any word after reset returns 0 until that word is rewritten.
- No X may propagate to golden_HRDATA: unwritten words are masked by their valid bit.

Decomposition:
- Shared package sdram_tb_pkg holds:
  - Field positions: REGION_MSB/LSB = 31/30, COL = 24:16, BANK = 15:14, ROW = 13:0.
  - REGION_CODE = 2'b10.
  - DATA_W.
- One sub-module, sdram_addr_decode (combinational), produces in_region, bank, row, col and idx from tb_HADDR.
- The memory array, valid bits and output register stay in sdram_ref_model.

Test Plan:
- Basic write/read: assert reset for 100 ns, release. Write 32'h49856712 to 32'h80000000, idle 5 cycles, read 32'h80000000. Expect golden_HRDATA = 32'h49856712 one cycle after the read sample.
- Bank/row/column isolation:
  - Write A5A5A5A5 to 32'h80004000 (bank 1), 5A5A5A5A to 32'h80010000 (column 1), 12345678 to 32'h80000001 (row 1).
  - Read each back: each returns its own value, and 32'h80000000 still returns 49856712.
- Region filter: write DEADBEEF to 32'h00000000, then read 32'h00000000 and 32'h80000000. Expect 32'h0, then the prior in-region value unchanged.
- Unwritten and reset:
  - Read 32'h80020000 before any write: expect 32'h0.
  - Write a value, pulse tb_HRESET asynchronously between clock edges: golden_HRDATA goes to 0 immediately.
  - A subsequent read of that address returns 0.
- Aliasing: write 11111111 to 32'h80000010 (row 16), then read 32'h80000000 (row 0). Expect 11111111 with the default ROW_IDX=4.
- Held transfer: hold a read of 32'h80000000 for 4 cycles with tb_HSEL=1. golden_HRDATA stays at the stored value each cycle, and then holds after tb_HSEL drops.
